// File: rtl/mips_regfile_sb.sv
// MIPS GPR file: two combinational read ports, two write ports (ALU and load/multicycle),
// optional write-to-read forwarding and a per-register busy scoreboard for decode hazards.
module mips_regfile_sb #(
  parameter  int WSIZE  = 32,
  parameter  int NREGS  = 32,
  localparam int AW     = $clog2(NREGS),
  parameter  int BYPASS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    ra_addr,
  input  logic             ra_use,
  output logic [WSIZE-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  input  logic             rb_use,
  output logic [WSIZE-1:0] rb_data,
  input  logic             wp0_en,
  input  logic [AW-1:0]    wp0_addr,
  input  logic [WSIZE-1:0] wp0_data,
  input  logic             wp1_en,
  input  logic [AW-1:0]    wp1_addr,
  input  logic [WSIZE-1:0] wp1_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic             hazard
);

  logic [WSIZE-1:0] regs_q [NREGS];
  logic [WSIZE-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wp0_live;
  logic wp1_live;
  logic iss_live;

  logic [WSIZE-1:0] ra_fwd;
  logic [WSIZE-1:0] rb_fwd;
  logic             ra_busy;
  logic             rb_busy;

  // Register 0 is never a destination, so every port qualifies on a nonzero address.
  assign wp0_live = wp0_en && (wp0_addr != '0);
  assign wp1_live = wp1_en && (wp1_addr != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  function automatic logic [WSIZE-1:0] read_port(
    input logic [AW-1:0]    addr,
    input logic [WSIZE-1:0] arr_val,
    input logic             w0_live,
    input logic [AW-1:0]    w0_addr,
    input logic [WSIZE-1:0] w0_data,
    input logic             w1_live,
    input logic [AW-1:0]    w1_addr,
    input logic [WSIZE-1:0] w1_data
  );
    logic [WSIZE-1:0] val;
    val = arr_val;
    if (addr == '0) begin
      val = '0;
    end else if (BYPASS != 0) begin
      // WP1 is checked last so it overrides WP0, matching the write priority.
      if (w0_live && (w0_addr == addr)) val = w0_data;
      if (w1_live && (w1_addr == addr)) val = w1_data;
    end
    return val;
  endfunction

  function automatic logic eff_busy(
    input logic [AW-1:0] addr,
    input logic          busy_bit,
    input logic          w1_live,
    input logic [AW-1:0] w1_addr
  );
    logic b;
    b = busy_bit && (addr != '0);
    // A result landing on WP1 this cycle is forwarded, so it no longer blocks.
    if ((BYPASS != 0) && w1_live && (w1_addr == addr)) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wp0_live) regs_d[wp0_addr] = wp0_data;
    if (wp1_live) regs_d[wp1_addr] = wp1_data;
    regs_d[0] = '0;
  end

  always_comb begin
    busy_d = busy_q;
    if (wp1_live) busy_d[wp1_addr] = 1'b0;
    // A fresh reservation on the same register outranks the clearing write.
    if (iss_live) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    ra_fwd  = read_port(ra_addr, regs_q[ra_addr], wp0_live, wp0_addr, wp0_data,
                        wp1_live, wp1_addr, wp1_data);
    rb_fwd  = read_port(rb_addr, regs_q[rb_addr], wp0_live, wp0_addr, wp0_data,
                        wp1_live, wp1_addr, wp1_data);
    ra_busy = eff_busy(ra_addr, busy_q[ra_addr], wp1_live, wp1_addr);
    rb_busy = eff_busy(rb_addr, busy_q[rb_addr], wp1_live, wp1_addr);
  end

  // Outputs are forced quiet during reset so forwarding cannot leak write data.
  assign ra_data  = reset ? '0 : ra_fwd;
  assign rb_data  = reset ? '0 : rb_fwd;
  assign busy_vec = busy_q;
  assign hazard   = !reset && ((ra_use && ra_busy) || (rb_use && rb_busy));

endmodule
